// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_pkg
// Shared types and constants for the fetch sequencer.
//   fetch_state_e  : fetch FSM states
//   INSTR_BYTES    : size of one instruction, used for sequential advance
//   PC_ALIGN_MASK  : clears PC bits [1:0]
//   align_pc()     : word-aligns an address
// ---------------------------------------------------------------------------
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_DRAIN,
    ST_ERR
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES   = 4;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_timer.sv
// ---------------------------------------------------------------------------
// fetch_timer
// Saturating cycle counter that measures how long the fetcher has waited for
// an instruction-memory response.
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-low reset
//   i_clear    : restart the count at zero (priority over i_enable)
//   i_enable   : count this cycle
//   o_expired  : high during the TIMEOUT_CYCLES-th enabled cycle and after
// ---------------------------------------------------------------------------
module fetch_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  // The count holds the number of enabled cycles already completed, so the
  // cycle that sees LAST is the TIMEOUT_CYCLES-th one. Saturating at LAST
  // keeps o_expired asserted if the owner keeps waiting.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Fetch sequencer: drives the PC register load, issues instruction-memory
// requests from the current PC, buffers the returned word for decode and
// handles redirects and lost-response timeouts.
//   i_clk / i_rst            : clock, asynchronous active-low reset
//   i_pc                     : current PC register value
//   o_pc_en / o_pc_next      : PC register load enable and next value
//   o_imem_req_valid/_ready  : request handshake, o_imem_addr = i_pc
//   i_imem_rsp_valid/_data   : one-cycle response pulse and instruction word
//   o_instr_valid / o_instr  : buffered instruction, consumed by i_instr_ready
//   i_stall                  : hold the issued instruction and the PC
//   i_redirect_valid/_pc     : taken branch/jump target
//   o_fetch_err              : sticky timeout indication
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  output logic        o_pc_en,
  output logic [31:0] o_pc_next,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  input  logic        i_instr_ready,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fetch_err
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_instr;
  logic         r_instr_valid;
  logic         w_redirect;
  logic         w_capture;
  logic         w_pc_en;
  logic [31:0]  w_pc_next;
  logic         w_req_valid;
  logic         w_timer_clr;
  logic         w_timer_en;
  logic         w_expired;

  // A redirect in BOOT is ignored so the reset vector always loads first.
  assign w_redirect  = i_redirect_valid && (r_state != ST_BOOT);
  assign w_timer_en  = (r_state == ST_WAIT) || (r_state == ST_DRAIN);
  assign w_timer_clr = (w_state_next != r_state);

  fetch_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_timer_clr),
    .i_enable  (w_timer_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Redirect is checked first in every state so it beats stall, sequential
  // advance and timeout. From WAIT/DRAIN the in-flight response still has to
  // be absorbed, unless it arrives in the same cycle as the redirect.
  always_comb begin
    w_state_next = r_state;
    w_pc_en      = 1'b0;
    w_pc_next    = align_pc(i_pc + 32'(INSTR_BYTES));
    w_req_valid  = 1'b0;
    w_capture    = 1'b0;
    if (w_redirect) begin
      w_pc_next = align_pc(i_redirect_pc);
    end
    unique case (r_state)
      ST_BOOT: begin
        w_pc_en      = 1'b1;
        w_pc_next    = align_pc(RESET_VECTOR);
        w_state_next = ST_REQ;
      end
      ST_REQ: begin
        if (w_redirect) begin
          w_pc_en = 1'b1;
        end else begin
          w_req_valid = 1'b1;
          if (i_imem_req_ready) begin
            w_state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_redirect) begin
          w_pc_en      = 1'b1;
          w_state_next = i_imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (i_imem_rsp_valid) begin
          w_capture    = 1'b1;
          w_state_next = ST_ISSUE;
        end else if (w_expired) begin
          w_state_next = ST_ERR;
        end
      end
      ST_ISSUE: begin
        if (w_redirect) begin
          w_pc_en      = 1'b1;
          w_state_next = ST_REQ;
        end else if (i_instr_ready && !i_stall) begin
          w_pc_en      = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (w_redirect) begin
          w_pc_en      = 1'b1;
          w_state_next = i_imem_rsp_valid ? ST_REQ : ST_DRAIN;
        end else if (i_imem_rsp_valid) begin
          w_state_next = ST_REQ;
        end else if (w_expired) begin
          w_state_next = ST_ERR;
        end
      end
      ST_ERR: begin
        if (w_redirect) begin
          w_pc_en      = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  // Any PC load means the buffered word no longer belongs to the PC, so the
  // buffer is invalidated on advance and on redirect alike.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else if (w_capture) begin
      r_instr       <= i_imem_rsp_data;
      r_instr_valid <= 1'b1;
    end else if (w_pc_en) begin
      r_instr_valid <= 1'b0;
    end
  end

  // BOOT asserts the load combinationally; gating with reset keeps the PC
  // register quiet while reset is held.
  assign o_pc_en          = w_pc_en && i_rst;
  assign o_pc_next        = w_pc_next;
  assign o_imem_req_valid = w_req_valid;
  assign o_imem_addr      = i_pc;
  assign o_instr_valid    = r_instr_valid;
  assign o_instr          = r_instr;
  assign o_fetch_err      = (r_state == ST_ERR);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed bench for pc_fetch_ctrl with a PC register and instruction memory
// model around the DUT, a per-cycle reference model of the fetch contract and
// literal expectations for the key scenarios.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RV  = 32'h0000_0100;
  localparam int          TMO = 16;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pcEn;
  logic [31:0] pcNext;
  logic        reqValid;
  logic        reqReady = 1'b1;
  logic [31:0] imemAddr;
  logic        rspValid = 1'b0;
  logic [31:0] rspData = 32'h0;
  logic        instrValid;
  logic [31:0] instr;
  logic        instrReady = 1'b1;
  logic        stall = 1'b0;
  logic        redirValid = 1'b0;
  logic [31:0] redirPc = 32'h0;
  logic        fetchErr;

  pc_fetch_ctrl #(
    .RESET_VECTOR   (RV),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rstN),
    .i_pc             (pc),
    .o_pc_en          (pcEn),
    .o_pc_next        (pcNext),
    .o_imem_req_valid (reqValid),
    .i_imem_req_ready (reqReady),
    .o_imem_addr      (imemAddr),
    .i_imem_rsp_valid (rspValid),
    .i_imem_rsp_data  (rspData),
    .o_instr_valid    (instrValid),
    .o_instr          (instr),
    .i_instr_ready    (instrReady),
    .i_stall          (stall),
    .i_redirect_valid (redirValid),
    .i_redirect_pc    (redirPc),
    .o_fetch_err      (fetchErr)
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a == 32'h0000_010C) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
  endfunction

  // Memory and PC register environment. Decisions use values sampled on the
  // falling edge; updates land 1 time unit after the rising edge.
  logic        memDrop  = 1'b0;
  int          memDelay = 0;
  logic        envPend;
  logic [31:0] envAddr;
  int          envLeft;
  logic        sEn, sHs, sDrop;
  logic [31:0] sNext, sAddr;
  int          sDelay;

  initial begin
    envPend = 1'b0;
    envAddr = 32'h0;
    envLeft = 0;
    forever begin
      @(negedge clk);
      sEn    = pcEn;
      sNext  = pcNext;
      sHs    = reqValid && reqReady;
      sAddr  = imemAddr;
      sDrop  = memDrop;
      sDelay = memDelay;
      @(posedge clk);
      #1;
      if (sEn) pc = sNext;
      rspValid = 1'b0;
      rspData  = 32'h0;
      if (!rstN) begin
        envPend = 1'b0;
      end else begin
        if (sHs && !sDrop) begin
          envPend = 1'b1;
          envAddr = sAddr;
          envLeft = sDelay;
        end
        if (envPend) begin
          if (envLeft == 0) begin
            rspValid = 1'b1;
            rspData  = memWord(envAddr);
            envPend  = 1'b0;
          end else begin
            envLeft--;
          end
        end
      end
    end
  end

  // Reference model of the fetch contract, evaluated once per cycle.
  logic        prevRst = 1'b0;
  logic        expValid = 1'b0;
  logic [31:0] expInstr = 32'h0;
  logic        outstanding = 1'b0;
  logic        killed = 1'b0;
  logic        expErr = 1'b0;
  int          waitCnt = 0;
  int          cycleCnt = 0;
  int          hsCycleQ[$];
  logic [31:0] hsAddrQ[$];
  logic        mBoot, mRedir, mAdv, mEn, mReq, mNextValid;
  logic [31:0] mNext;

  initial begin
    forever begin
      @(negedge clk);
      cycleCnt++;
      if (!rstN) begin
        checkOutput("rstPcEn", {31'b0, pcEn}, 32'd0);
        checkOutput("rstPcNext", pcNext, RV);
        checkOutput("rstReq", {31'b0, reqValid}, 32'd0);
        checkOutput("rstInstrValid", {31'b0, instrValid}, 32'd0);
        checkOutput("rstErr", {31'b0, fetchErr}, 32'd0);
        expValid    = 1'b0;
        outstanding = 1'b0;
        killed      = 1'b0;
        expErr      = 1'b0;
        waitCnt     = 0;
        prevRst     = 1'b0;
      end else begin
        mBoot  = !prevRst;
        mRedir = redirValid && !mBoot;
        mAdv   = expValid && instrReady && !stall;
        mEn    = mBoot || mRedir || mAdv;
        mNext  = mBoot ? RV : (mRedir ? (redirPc & 32'hFFFF_FFFC) : (pc + 32'd4));
        mReq   = !(mBoot || mRedir || outstanding || expValid || expErr);
        checkOutput("pcEn", {31'b0, pcEn}, {31'b0, mEn});
        if (mEn) checkOutput("pcNext", pcNext, mNext);
        checkOutput("pcNextAlign", {30'b0, pcNext[1:0]}, 32'd0);
        checkOutput("imemAddr", imemAddr, pc);
        checkOutput("reqValid", {31'b0, reqValid}, {31'b0, mReq});
        checkOutput("instrValid", {31'b0, instrValid}, {31'b0, expValid});
        if (expValid) checkOutput("instr", instr, expInstr);
        checkOutput("fetchErr", {31'b0, fetchErr}, {31'b0, expErr});

        mNextValid = expValid;
        if (mRedir || mAdv) mNextValid = 1'b0;
        if (mRedir) expErr = 1'b0;
        if (outstanding) begin
          if (rspValid) begin
            if (!killed && !mRedir) begin
              mNextValid = 1'b1;
              expInstr   = rspData;
            end
            outstanding = 1'b0;
          end else if (mRedir) begin
            if (!killed) begin
              killed  = 1'b1;
              waitCnt = 0;
            end else if (waitCnt < TMO - 1) begin
              waitCnt++;
            end
          end else if (waitCnt == TMO - 1) begin
            expErr      = 1'b1;
            outstanding = 1'b0;
          end else begin
            waitCnt++;
          end
        end
        if (mReq && reqReady) begin
          outstanding = 1'b1;
          killed      = 1'b0;
          waitCnt     = 0;
          hsCycleQ.push_back(cycleCnt);
          hsAddrQ.push_back(pc);
        end
        expValid = mNextValid;
        prevRst  = 1'b1;
      end
    end
  end

  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic st);
    @(posedge clk);
    #1;
    redirValid = redir;
    redirPc    = rpc;
    stall      = st;
    #2;
  endtask

  task automatic waitReq(input logic [31:0] addr, input string name);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      n++;
    end while (!reqValid && n < 12);
    checkOutput({name, "Req"}, {31'b0, reqValid}, 32'd1);
    checkOutput({name, "Addr"}, imemAddr, addr);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t0RstPcNext", pcNext, 32'h0000_0100);
    checkOutput("t0RstPcEn", {31'b0, pcEn}, 32'd0);

    // Reset release and zero-wait fetch loop
    @(posedge clk);
    #1;
    rstN = 1'b1;
    hsAddrQ.delete();
    hsCycleQ.delete();
    #2;
    checkOutput("t1BootEn", {31'b0, pcEn}, 32'd1);
    checkOutput("t1BootNext", pcNext, 32'h0000_0100);
    checkOutput("t1BootReq", {31'b0, reqValid}, 32'd0);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t1ReqCount", (hsAddrQ.size() >= 3) ? 32'd3 : hsAddrQ.size(), 32'd3);
    if (hsAddrQ.size() >= 3) begin
      checkOutput("t1Addr0", hsAddrQ[0], 32'h0000_0100);
      checkOutput("t1Addr1", hsAddrQ[1], 32'h0000_0104);
      checkOutput("t1Addr2", hsAddrQ[2], 32'h0000_0108);
      checkOutput("t1Gap01", hsCycleQ[1] - hsCycleQ[0], 32'd3);
      checkOutput("t1Gap12", hsCycleQ[2] - hsCycleQ[1], 32'd3);
    end

    // Stall held for 4 cycles in ISSUE
    waitReq(32'h0000_010C, "t2");
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("t2HoldValid", {31'b0, instrValid}, 32'd1);
      checkOutput("t2HoldInstr", instr, 32'h0050_0093);
      checkOutput("t2HoldPcEn", {31'b0, pcEn}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t2AdvEn", {31'b0, pcEn}, 32'd1);
    checkOutput("t2AdvNext", pcNext, 32'h0000_0110);

    // Redirect in WAIT, response two cycles later is discarded
    memDelay = 2;
    waitReq(32'h0000_0110, "t3");
    applyStimulus(1'b1, 32'h0000_0203, 1'b0);
    memDelay = 0;
    checkOutput("t3RedirEn", {31'b0, pcEn}, 32'd1);
    checkOutput("t3RedirNext", pcNext, 32'h0000_0200);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3DrainReq", {31'b0, reqValid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3DropValid", {31'b0, instrValid}, 32'd0);
    checkOutput("t3DropReq", {31'b0, reqValid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t3NewReq", {31'b0, reqValid}, 32'd1);
    checkOutput("t3NewAddr", imemAddr, 32'h0000_0200);
    memDrop = 1'b1;

    // Lost response: error after TIMEOUT_CYCLES cycles of waiting
    for (int k = 0; k < TMO; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("t4ErrEarly", {31'b0, fetchErr}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4ErrSet", {31'b0, fetchErr}, 32'd1);
    memDrop = 1'b0;
    repeat (3) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("t4ErrSticky", {31'b0, fetchErr}, 32'd1);
      checkOutput("t4ErrNoReq", {31'b0, reqValid}, 32'd0);
    end
    applyStimulus(1'b1, 32'h0000_0040, 1'b0);
    checkOutput("t4RedirEn", {31'b0, pcEn}, 32'd1);
    checkOutput("t4RedirNext", pcNext, 32'h0000_0040);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t4ErrClear", {31'b0, fetchErr}, 32'd0);
    checkOutput("t4Req", {31'b0, reqValid}, 32'd1);
    checkOutput("t4Addr", imemAddr, 32'h0000_0040);

    // Redirect in ISSUE to top of memory, then sequential wrap
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
    checkOutput("t5IssueInstr", instr, 32'h1357_9B9F);
    checkOutput("t5RedirNext", pcNext, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t5TopAddr", imemAddr, 32'hFFFF_FFFC);
    checkOutput("t5TopValid", {31'b0, instrValid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t5TopInstr", instr, 32'hECA8_6423);
    checkOutput("t5WrapEn", {31'b0, pcEn}, 32'd1);
    checkOutput("t5WrapNext", pcNext, 32'h0000_0000);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t5WrapAddr", imemAddr, 32'h0000_0000);

    // Redirect and response in the same WAIT cycle
    applyStimulus(1'b1, 32'h0000_0080, 1'b0);
    checkOutput("t6RedirNext", pcNext, 32'h0000_0080);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t6Req", {31'b0, reqValid}, 32'd1);
    checkOutput("t6Addr", imemAddr, 32'h0000_0080);
    checkOutput("t6NoIssue", {31'b0, instrValid}, 32'd0);

    // Reset asserted mid-fetch
    @(posedge clk);
    #1;
    rstN = 1'b0;
    #2;
    checkOutput("t7RstPcEn", {31'b0, pcEn}, 32'd0);
    checkOutput("t7RstReq", {31'b0, reqValid}, 32'd0);
    repeat (2) applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    rstN = 1'b1;
    #2;
    checkOutput("t7BootNext", pcNext, 32'h0000_0100);
    checkOutput("t7BootEn", {31'b0, pcEn}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t7ReqAddr", imemAddr, 32'h0000_0100);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer that owns the PC register's enable and next-value inputs. It drives instruction-memory requests from the current PC, buffers the returned instruction for decode, and advances the PC sequentially or on a branch/jump redirect. It guards against lost responses with a timeout, and sits between the PC register, instruction memory and the decode stage of the single-cycle core.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- TIMEOUT_CYCLES, 16, max cycles in WAIT before error (≥2)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-low
- i_pc  in  32  current PC from PC register
- o_pc_en  out  1  PC register load enable
- o_pc_next  out  32  PC register next value, bits [1:0] always 0
- o_imem_req_valid  out  1  fetch request valid
- i_imem_req_ready  in  1  memory accepts request
- o_imem_addr  out  32  fetch address (= i_pc)
- i_imem_rsp_valid  in  1  response valid, one-cycle pulse
- i_imem_rsp_data  in  32  response instruction word
- o_instr_valid  out  1  buffered instruction valid to decode
- o_instr  out  32  buffered instruction
- i_instr_ready  in  1  decode consumes instruction
- i_stall  in  1  hold PC/instruction (hazard)
- i_redirect_valid  in  1  branch/jump taken
- i_redirect_pc  in  32  redirect target
- o_fetch_err  out  1  sticky fetch timeout

## Operation
- FSM states: BOOT, REQ, WAIT, ISSUE, DRAIN, ERR. Reset state BOOT.
- BOOT: o_pc_en=1, o_pc_next=RESET_VECTOR for exactly one cycle after reset release -> REQ.
- REQ: o_imem_req_valid=1 unless i_redirect_valid; handshake (valid&&ready) -> WAIT, timer cleared.
- WAIT: on i_imem_rsp_valid, capture data into instr buffer -> ISSUE; timer reaches TIMEOUT_CYCLES -> ERR.
- ISSUE: o_instr_valid=1. When i_instr_ready && !i_stall: o_pc_en=1, o_pc_next=i_pc+4 (mod 2^32, wrap 0xFFFF_FFFC→0) -> REQ. i_stall holds everything.
- DRAIN: outstanding response is discarded; on i_imem_rsp_valid -> REQ; timeout -> ERR.
- ERR: o_fetch_err=1, no requests; only redirect or reset leaves.
- Redirect (any state but BOOT): o_pc_en=1, o_pc_next={i_redirect_pc[31:2],2'b00}; instr buffer invalidated. Next state: REQ from REQ/ISSUE/ERR (ERR clears o_fetch_err); DRAIN from WAIT (REQ if rsp_valid same cycle, response dropped); stays DRAIN from DRAIN (REQ if rsp_valid same cycle).
- Redirect beats i_stall and sequential advance; redirect during BOOT ignored.
- o_pc_en is never asserted outside BOOT, ISSUE advance, or redirect.

## Timing
- While i_rst=0: state BOOT, all outputs 0 except o_pc_next=RESET_VECTOR, o_imem_addr=i_pc; buffer cleared, timer 0.
- o_pc_en/o_pc_next/o_imem_req_valid combinational from state and inputs; PC register updates on the following edge.
- Minimum fetch loop with zero-wait memory: REQ→WAIT→ISSUE→REQ, 3 cycles per instruction.
- o_instr/o_instr_valid registered; valid the cycle after rsp capture.
- Timer counts WAIT/DRAIN cycles; saturates, reset on state entry.
- Reset asserted mid-operation: immediate return to BOOT; outstanding response after release ignored only via normal REQ/WAIT flow (memory is reset alongside).

## Structure
- Package pc_fetch_pkg: state enum fetch_state_e, INSTR_BYTES=4, PC_ALIGN_MASK=32'hFFFF_FFFC.
- One sub-module: fetch_timer (clear, enable, saturating count, o_expired at TIMEOUT_CYCLES).

## Test plan
- Reset release, RESET_VECTOR=0x100, zero-wait memory -> pc_en pulse with 0x100, requests 0x100, 0x104, 0x108 every 3 cycles.
- Response 0x00500093 with i_stall=1 for 4 cycles in ISSUE -> o_instr held valid, no pc_en until stall drops, then pc_next=i_pc+4.
- Redirect to 0x203 in WAIT, response arrives 2 cycles later -> pc_next=0x200, response discarded, next request to 0x200.
- No response for TIMEOUT_CYCLES=16 -> o_fetch_err=1 at cycle 16, no further requests; redirect 0x40 clears error, request 0x40.
- i_pc=0xFFFF_FFFC advance -> o_pc_next=0x0000_0000.
- Redirect and i_imem_rsp_valid same WAIT cycle -> instruction not issued, state REQ next cycle.
